req_encoder32_arbiter: RTL

- Encoder-side counterpart of the 5-to-32 one-hot decoder.
- Collects up to 32 single-bit request events, e.g. per-register or per-source flags, into a pending register.
- Arbitrates among pending requests and emits one 5-bit index at a time over a VALID/READY handshake.
- Used wherever a one-hot or multi-hot vector must be serialised back into register-number form for the datapath.

---
 rtl/req_encoder32_arbiter.sv | 57 +++++
 1 files changed

// File: rtl/req_encoder32_arbiter.sv
// req_encoder32_arbiter: collects 32 request flags into a pending register and serialises them as 5-bit indices over VALID/READY
module req_encoder32_arbiter #(
  parameter bit RR = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [31:0] REQ,
  input  logic        READY,
  output logic        VALID,
  output logic [4:0]  IDX,
  output logic [31:0] PEND
);
  logic [31:0] r_pend;
  logic        r_valid;
  logic [4:0]  r_idx;
  logic [4:0]  r_ptr;
  logic        w_xfer;
  logic        w_free;
  logic [31:0] w_clr;
  logic [31:0] w_cap;
  logic [31:0] w_p;
  logic [4:0]  w_base;
  logic [31:0] w_rot;
  logic [4:0]  w_sel;
  // the pointer used for selection already reflects a grant retiring this cycle
  always_comb begin
    w_xfer = r_valid & READY;
    w_free = ~r_valid | w_xfer;
    w_clr  = w_xfer ? (32'd1 << r_idx) : 32'd0;
    w_cap  = EN ? REQ : 32'd0;
    w_p    = r_pend & ~w_clr;
    w_base = RR ? (w_xfer ? r_idx + 5'd1 : r_ptr) : 5'd0;
    w_rot  = (w_p >> w_base) | (w_p << (6'd32 - {1'b0, w_base}));
    w_sel  = 5'd0;
    for (int i = 31; i >= 0; i--)
      if (w_rot[i]) w_sel = 5'(i) + w_base;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pend  <= 32'd0;
      r_valid <= 1'b0;
      r_idx   <= 5'd0;
      r_ptr   <= 5'd0;
    end else begin
      r_pend <= w_p | w_cap;
      if (w_xfer) r_ptr <= r_idx + 5'd1;
      if (w_free) begin
        r_valid <= |w_p;
        if (|w_p) r_idx <= w_sel;
      end
    end
  end
  assign VALID = r_valid;
  assign IDX   = r_idx;
  assign PEND  = r_pend;
endmodule
